// File: rtl/vga_pixel_fifo.sv
// rtl/vga_pixel_fifo.sv - Avalon-MM write buffer feeding the VGA pixel serializer
// CPU-written 16-bit pixel words drain over a valid/ready stream; status, level and low-water irq.
module vga_pixel_fifo #(
  parameter int DEPTH     = 16,
  parameter int LOW_WATER = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic [1:0]  address,
  input  logic        write,
  input  logic [15:0] writedata,
  input  logic        read,
  output logic [15:0] readdata,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_LEVEL  = 2'd3;

  localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0] LEVEL_LOW  = LW'(LOW_WATER);

  logic [15:0]   r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [LW-1:0] r_level;
  logic          r_en;
  logic          r_irqen;
  logic          r_ovf;
  logic          r_unf;
  logic [15:0]   r_readdata;

  logic w_bus_wr;
  logic w_bus_rd;
  logic w_data_wr;
  logic w_ctrl_wr;
  logic w_stat_wr;
  logic w_clr;
  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_ovf_set;
  logic w_unf_set;

  assign w_bus_wr  = chipselect & write;
  assign w_bus_rd  = chipselect & read;
  assign w_data_wr = w_bus_wr & (address == ADDR_DATA);
  assign w_ctrl_wr = w_bus_wr & (address == ADDR_CTRL);
  assign w_stat_wr = w_bus_wr & (address == ADDR_STATUS);
  assign w_clr     = w_ctrl_wr & writedata[1];

  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == LEVEL_FULL);

  assign out_valid = r_en & ~w_empty;
  assign out_data  = r_mem[r_rd_ptr];
  assign readdata  = r_readdata;
  assign irq       = r_irqen & r_en & (r_level <= LEVEL_LOW);

  // Full is judged on the pre-edge level, so a same-cycle pop never rescues a write.
  assign w_push    = w_data_wr & ~w_full & ~w_clr;
  assign w_pop     = out_valid & out_ready & ~w_clr;
  assign w_ovf_set = w_data_wr & w_full;
  assign w_unf_set = r_en & out_ready & w_empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= writedata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_level  <= '0;
    end else if (w_clr) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_level <= r_level + 1'b1;
      end else if (w_pop && !w_push) begin
        r_level <= r_level - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_en    <= 1'b0;
      r_irqen <= 1'b0;
    end else if (w_ctrl_wr) begin
      r_en    <= writedata[0];
      r_irqen <= writedata[2];
    end
  end

  // Sticky flags: a set in the same cycle as a software clear wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (w_stat_wr && writedata[2]) begin
        r_ovf <= 1'b0;
      end
      if (w_unf_set) begin
        r_unf <= 1'b1;
      end else if (w_stat_wr && writedata[3]) begin
        r_unf <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_readdata <= '0;
    end else if (w_bus_rd) begin
      case (address)
        ADDR_DATA:   r_readdata <= '0;
        ADDR_CTRL:   r_readdata <= {13'd0, r_irqen, 1'b0, r_en};
        ADDR_STATUS: r_readdata <= {12'd0, r_unf, r_ovf, w_full, w_empty};
        ADDR_LEVEL:  r_readdata <= {{(16-LW){1'b0}}, r_level};
        default:     r_readdata <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_pixel_fifo.sv
// tb/tb_vga_pixel_fifo.sv - scoreboard bench for vga_pixel_fifo
// Expected words queue on accepted DATA writes and are compared as the stream hands them off.
module tb_vga_pixel_fifo;

  localparam int DEPTH     = 16;
  localparam int LOW_WATER = 4;

  logic        clk;
  logic        reset;
  logic        chipselect;
  logic [1:0]  address;
  logic        write;
  logic [15:0] writedata;
  logic        read;
  logic [15:0] readdata;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        irq;

  vga_pixel_fifo #(.DEPTH(DEPTH), .LOW_WATER(LOW_WATER)) dut (
    .clk        (clk),
    .reset      (reset),
    .chipselect (chipselect),
    .address    (address),
    .write      (write),
    .writedata  (writedata),
    .read       (read),
    .readdata   (readdata),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] sb_q[$];
  logic        m_en    = 1'b0;
  logic        m_irqen = 1'b0;
  logic        mon_valid;
  logic [15:0] mon_exp;
  logic [15:0] rd_val;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
    logic accept;
    accept     = (sb_q.size() < DEPTH);
    chipselect = 1'b1;
    write      = 1'b1;
    address    = a;
    writedata  = d;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write      = 1'b0;
    if (a == 2'd0 && accept) sb_q.push_back(d);
    if (a == 2'd1) begin
      m_en    = d[0];
      m_irqen = d[2];
      if (d[1]) sb_q.delete();
    end
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [15:0] d);
    chipselect = 1'b1;
    read       = 1'b1;
    address    = a;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    read       = 1'b0;
    d          = readdata;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      mon_valid = m_en && (sb_q.size() != 0);
      check_eq("out_valid", out_valid, mon_valid);
      check_eq("irq", irq, m_irqen && m_en && (sb_q.size() <= LOW_WATER));
      if (mon_valid && out_ready) begin
        mon_exp = sb_q.pop_front();
        check_eq("out_data", out_data, mon_exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset      = 1'b1;
    chipselect = 1'b0;
    address    = '0;
    write      = 1'b0;
    writedata  = '0;
    read       = 1'b0;
    out_ready  = 1'b0;
    idle(2);
    check_eq("rst_readdata", readdata, 16'h0);
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_irq", irq, 1'b0);
    reset = 1'b0;
    bus_read(2'd3, rd_val);
    check_eq("rst_level", rd_val, 16'd0);

    // basic stream in order
    bus_write(2'd1, 16'h0001);
    bus_write(2'd0, 16'h1111);
    bus_write(2'd0, 16'h2222);
    bus_write(2'd0, 16'h3333);
    bus_read(2'd3, rd_val);
    check_eq("level_3", rd_val, 16'd3);
    check_eq("head_valid", out_valid, 1'b1);
    check_eq("head_data", out_data, 16'h1111);
    out_ready = 1'b1;
    idle(3);
    out_ready = 1'b0;
    bus_read(2'd2, rd_val);
    check_eq("status_empty", rd_val, 16'h1);

    // fill to full, overflow drop
    bus_write(2'd1, 16'h0000);
    for (int i = 0; i < DEPTH; i++) bus_write(2'd0, 16'($urandom));
    bus_write(2'd0, 16'hDEAD);
    bus_read(2'd2, rd_val);
    check_eq("status_full_ovf", rd_val, 16'h6);
    bus_read(2'd3, rd_val);
    check_eq("level_full", rd_val, 16'd16);
    bus_write(2'd2, 16'h0004);
    bus_read(2'd2, rd_val);
    check_eq("ovf_cleared", rd_val, 16'h2);

    // full write with concurrent pop
    bus_write(2'd1, 16'h0001);
    out_ready = 1'b1;
    bus_write(2'd0, 16'hBEEF);
    out_ready = 1'b0;
    bus_read(2'd2, rd_val);
    check_eq("status_drop_pop", rd_val, 16'h4);
    bus_read(2'd3, rd_val);
    check_eq("level_15", rd_val, 16'd15);
    bus_write(2'd2, 16'h0004);

    // half full, push+pop across the pointer wrap
    out_ready = 1'b1;
    idle(7);
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) bus_write(2'd0, 16'($urandom));
    out_ready = 1'b0;
    bus_read(2'd3, rd_val);
    check_eq("level_steady", rd_val, 16'd8);

    // underflow sticky
    out_ready = 1'b1;
    idle(9);
    out_ready = 1'b0;
    bus_read(2'd2, rd_val);
    check_eq("status_unf", rd_val, 16'h9);
    idle(3);
    bus_read(2'd2, rd_val);
    check_eq("unf_sticky", rd_val, 16'h9);
    bus_write(2'd2, 16'h0008);
    bus_read(2'd2, rd_val);
    check_eq("unf_cleared", rd_val, 16'h1);

    // low-water irq
    bus_write(2'd1, 16'h0005);
    for (int i = 0; i < 6; i++) bus_write(2'd0, 16'h0A00 + 16'(i));
    check_eq("irq_level6", irq, 1'b0);
    out_ready = 1'b1;
    idle(1);
    check_eq("irq_level5", irq, 1'b0);
    idle(1);
    check_eq("irq_level4", irq, 1'b1);
    out_ready = 1'b0;
    bus_write(2'd0, 16'h0B0B);
    check_eq("irq_back_5", irq, 1'b0);

    // CLR during a pop
    out_ready = 1'b1;
    bus_write(2'd1, 16'h0007);
    out_ready = 1'b0;
    check_eq("clr_valid", out_valid, 1'b0);
    bus_read(2'd3, rd_val);
    check_eq("clr_level", rd_val, 16'd0);
    bus_read(2'd1, rd_val);
    check_eq("clr_ctrl", rd_val, 16'h5);

    // reset mid-stream
    for (int i = 0; i < 3; i++) bus_write(2'd0, 16'hC000 + 16'(i));
    out_ready = 1'b1;
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_eq("arst_valid", out_valid, 1'b0);
    check_eq("arst_irq", irq, 1'b0);
    sb_q.delete();
    m_en      = 1'b0;
    m_irqen   = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus_write(2'd0, 16'h5A5A);
    bus_read(2'd3, rd_val);
    check_eq("post_rst_level", rd_val, 16'd1);
    bus_read(2'd1, rd_val);
    check_eq("post_rst_ctrl", rd_val, 16'h0);
    bus_read(2'd2, rd_val);
    check_eq("post_rst_status", rd_val, 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
